multicycle_control: RTL and testbench

//  Main control FSM for the multicycle RV64I datapath. Sequences fetch, decode, execute, memory and writeback.

---
 rtl/multicycle_control_pkg.sv | 37 +++
 rtl/multicycle_control_if.sv | 12 +
 rtl/multicycle_control_mem_wait_timer.sv | 31 +++
 rtl/multicycle_control.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle RV64I control path.
//   opcodes  : major opcode constants (i_instr[6:0]) of the supported formats.
//   ctrl_pkg : FSM state enum, datapath select/op enums, trap causes and
//              branch funct3 codes used by multicycle_control.
package opcodes;
  localparam logic [6:0] LD        = 7'b0000011;
  localparam logic [6:0] IMM_ARITH = 7'b0010011;
  localparam logic [6:0] TYPE_S    = 7'b0100011;
  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] TYPE_U    = 7'b0110111;
  localparam logic [6:0] TYPE_SB   = 7'b1100011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] TYPE_UJ   = 7'b1101111;
endpackage

package ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
  } state_t;

  typedef enum logic [1:0] {A_PC = 2'd0, A_OLDPC = 2'd1, A_RS1 = 2'd2} alu_src_a_t;
  typedef enum logic [1:0] {B_RS2 = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2} alu_src_b_t;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_CMP = 2'd1, OP_FUNCT = 2'd2} alu_op_t;
  typedef enum logic [1:0] {PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_ALU_LSB0 = 2'd2} pc_src_t;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2, WB_IMM = 2'd3} wb_sel_t;
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0, CAUSE_ILLEGAL = 2'd1, CAUSE_TIMEOUT = 2'd2
  } trap_cause_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/multicycle_control_if.sv
// Request/acknowledge handshake between the control FSM and unified memory.
//   req : request pending, held until ack
//   we  : request is a store, stable while req is held
//   ack : memory completed the held request this cycle
interface multicycle_control_if;
  logic req;
  logic we;
  logic ack;

  modport master (output req, output we, input ack);
  modport slave  (input req, input we, output ack);
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts cycles a memory request has waited without acknowledge.
//   i_clk, i_reset : clock, synchronous active-high reset (count -> 0)
//   i_clear        : restart the count at 0
//   i_count        : one more waiting cycle
//   o_expired      : count has reached MEM_TIMEOUT
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);
  localparam int unsigned W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] count_q, count_d;

  assign o_expired = (count_q == W'(MEM_TIMEOUT));

  always_comb begin
    count_d = count_q;
    if (i_clear)                     count_d = '0;
    else if (i_count && !o_expired)  count_d = count_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) count_q <= '0;
    else         count_q <= count_d;
  end
endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV64I datapath: fetch, decode, execute,
// memory, writeback. Drives datapath selects/strobes and the memory handshake,
// traps on illegal opcodes and on memory requests that wait too long.
//   i_clk, i_reset    : clock, synchronous active-high reset
//   i_instr           : current IR contents
//   i_zero, i_lt      : ALU flags for branch resolution
//   mem (master)      : req/we out, ack in
//   o_addr_sel .. o_wb_sel : datapath mux selects and write strobes
//   o_retired         : one-cycle pulse per completed instruction
//   o_trap, o_trap_cause : sticky trap flag and its cause
module multicycle_control
  import ctrl_pkg::*;
  import opcodes::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [31:0]          i_instr,
  input  logic                 i_zero,
  input  logic                 i_lt,
  multicycle_control_if.master mem,
  output logic                 o_addr_sel,
  output logic                 o_ir_write,
  output logic                 o_pc_write,
  output logic [1:0]           o_pc_src,
  output logic [1:0]           o_alu_src_a,
  output logic [1:0]           o_alu_src_b,
  output logic [1:0]           o_alu_op,
  output logic                 o_aluout_write,
  output logic                 o_reg_write,
  output logic [1:0]           o_wb_sel,
  output logic                 o_retired,
  output logic                 o_trap,
  output logic [1:0]           o_trap_cause
);
  state_t      state_q, state_d;
  trap_cause_t cause_q, cause_d;

  alu_src_a_t src_a;
  alu_src_b_t src_b;
  alu_op_t    alu_op;
  pc_src_t    pc_src;
  wb_sel_t    wb_sel;
  logic       req, we, taken;
  logic       timer_clear, timer_count, timer_expired;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr;

  assign opcode       = i_instr[6:0];
  assign funct3       = i_instr[14:12];
  assign unused_instr = ^{i_instr[31:15], i_instr[11:7]};

  always_comb begin
    unique case (funct3)
      F3_BEQ:           taken = i_zero;
      F3_BNE:           taken = ~i_zero;
      F3_BLT, F3_BLTU:  taken = i_lt;
      F3_BGE, F3_BGEU:  taken = ~i_lt;
      default:          taken = 1'b0;
    endcase
  end

  // Every output is forced low while i_reset is high, so a reset mid-instruction
  // never leaks a strobe or retire pulse.
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    req            = 1'b0;
    we             = 1'b0;
    o_addr_sel     = 1'b0;
    o_ir_write     = 1'b0;
    o_pc_write     = 1'b0;
    pc_src         = PC_ALU;
    src_a          = A_PC;
    src_b          = B_RS2;
    alu_op         = OP_ADD;
    o_aluout_write = 1'b0;
    o_reg_write    = 1'b0;
    wb_sel         = WB_ALU;
    o_retired      = 1'b0;
    o_trap         = 1'b0;
    o_trap_cause   = CAUSE_NONE;
    if (!i_reset) begin
      case (state_q)
        S_FETCH: begin
          req = 1'b1;
          if (mem.ack) begin
            o_ir_write = 1'b1;
            o_pc_write = 1'b1;
            src_b      = B_FOUR;
            state_d    = S_DECODE;
          end else if (timer_expired) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        S_DECODE: begin
          src_a          = A_OLDPC;
          src_b          = B_IMM;
          o_aluout_write = 1'b1;
          case (opcode)
            R_TYPE:      state_d = S_EXEC_R;
            IMM_ARITH:   state_d = S_EXEC_I;
            LD, TYPE_S:  state_d = S_ADDR;
            TYPE_SB:     state_d = S_BRANCH;
            TYPE_UJ:     state_d = S_JAL;
            JALR:        state_d = S_JALR;
            TYPE_U:      state_d = S_LUI;
            default: begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          endcase
        end
        S_EXEC_R, S_EXEC_I: begin
          src_a          = A_RS1;
          src_b          = (state_q == S_EXEC_R) ? B_RS2 : B_IMM;
          alu_op         = OP_FUNCT;
          o_aluout_write = 1'b1;
          state_d        = S_WB_ALU;
        end
        S_ADDR: begin
          src_a          = A_RS1;
          src_b          = B_IMM;
          o_aluout_write = 1'b1;
          state_d        = (opcode == LD) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD, S_MEM_WR: begin
          req        = 1'b1;
          we         = (state_q == S_MEM_WR);
          o_addr_sel = 1'b1;
          if (mem.ack) begin
            o_retired = (state_q == S_MEM_WR);
            state_d   = (state_q == S_MEM_WR) ? S_FETCH : S_WB_MEM;
          end else if (timer_expired) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        S_WB_ALU, S_WB_MEM: begin
          o_reg_write = 1'b1;
          wb_sel      = (state_q == S_WB_MEM) ? WB_MDR : WB_ALU;
          o_retired   = 1'b1;
          state_d     = S_FETCH;
        end
        S_BRANCH: begin
          src_a      = A_RS1;
          src_b      = B_RS2;
          alu_op     = OP_CMP;
          o_pc_write = taken;
          pc_src     = PC_ALUOUT;
          o_retired  = 1'b1;
          state_d    = S_FETCH;
        end
        S_JAL: begin
          o_reg_write = 1'b1;
          wb_sel      = WB_PC;
          o_pc_write  = 1'b1;
          pc_src      = PC_ALUOUT;
          o_retired   = 1'b1;
          state_d     = S_FETCH;
        end
        S_JALR: begin
          src_a       = A_RS1;
          src_b       = B_IMM;
          pc_src      = PC_ALU_LSB0;
          o_pc_write  = 1'b1;
          o_reg_write = 1'b1;
          wb_sel      = WB_PC;
          o_retired   = 1'b1;
          state_d     = S_FETCH;
        end
        S_LUI: begin
          o_reg_write = 1'b1;
          wb_sel      = WB_IMM;
          o_retired   = 1'b1;
          state_d     = S_FETCH;
        end
        S_TRAP: begin
          o_trap       = 1'b1;
          o_trap_cause = cause_q;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Timer restarts whenever a request-holding state is freshly entered.
  always_comb begin
    timer_count = req && !mem.ack;
    timer_clear = (state_d != state_q) &&
                  (state_d inside {S_FETCH, S_MEM_RD, S_MEM_WR});
  end

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (timer_clear),
    .i_count   (timer_count),
    .o_expired (timer_expired)
  );

  assign mem.req     = req;
  assign mem.we      = we;
  assign o_pc_src    = pc_src;
  assign o_alu_src_a = src_a;
  assign o_alu_src_b = src_b;
  assign o_alu_op    = alu_op;
  assign o_wb_sel    = wb_sel;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT = 4). Each cycle the
// inputs are applied after the rising edge and the packed control word is
// compared against a hand-built expected word.
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero, lt;
  logic        addr_sel, ir_write, pc_write, aluout_write, reg_write, retired, trap;
  logic [1:0]  pc_src, src_a, src_b, alu_op, wb_sel, cause;
  logic [20:0] ctl;
  int          errors = 0;
  int          checks = 0;

  multicycle_control_if mem_if ();

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_zero(zero), .i_lt(lt),
    .mem(mem_if), .o_addr_sel(addr_sel), .o_ir_write(ir_write),
    .o_pc_write(pc_write), .o_pc_src(pc_src), .o_alu_src_a(src_a),
    .o_alu_src_b(src_b), .o_alu_op(alu_op), .o_aluout_write(aluout_write),
    .o_reg_write(reg_write), .o_wb_sel(wb_sel), .o_retired(retired),
    .o_trap(trap), .o_trap_cause(cause)
  );

  always #5 clk = ~clk;

  assign ctl = {mem_if.req, mem_if.we, addr_sel, ir_write, pc_write, pc_src,
                src_a, src_b, alu_op, aluout_write, reg_write, wb_sel,
                retired, trap, cause};

  // Field order: req we addr_sel ir_write pc_write pc_src a b op
  //              aluout_write reg_write wb_sel retired trap cause
  function automatic logic [20:0] pk(input int req, we, as, irw, pcw, pcs, a, b,
                                     op, aow, rw, wb, ret, trp, cs);
    return {1'(req), 1'(we), 1'(as), 1'(irw), 1'(pcw), 2'(pcs), 2'(a), 2'(b),
            2'(op), 1'(aow), 1'(rw), 2'(wb), 1'(ret), 1'(trp), 2'(cs)};
  endfunction

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, let logic settle, compare, advance.
  task automatic cyc(input string tag, input logic r, input logic [31:0] ins,
                     input logic ack, input logic z, input logic l,
                     input logic [20:0] exp);
    rst = r; instr = ins; mem_if.ack = ack; zero = z; lt = l;
    #1;
    check(tag, ctl, exp);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] LDI  = 32'h0080B103;  // ld   x2,8(x1)
  localparam logic [31:0] ADDR = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] BLT  = 32'h0020C463;
  localparam logic [31:0] BGE  = 32'h0020D463;
  localparam logic [31:0] JALI = 32'h008000EF;
  localparam logic [31:0] JALR = 32'h000080E7;
  localparam logic [31:0] LUI  = 32'h000010B7;
  localparam logic [31:0] SD   = 32'h0020B023;
  localparam logic [31:0] ILL  = 32'h0000007F;

  logic [20:0] Z, F, FA, DEC, EXI, EXR, WBA, ADR, MRD, WBM, MWR, MWRA;
  logic [20:0] BRT, BRN, WJAL, WJALR, WLUI, TR1, TR2;

  initial begin
    Z     = '0;
    F     = pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    FA    = pk(1,0,0,1,1,0,0,1,0,0,0,0,0,0,0);
    DEC   = pk(0,0,0,0,0,0,1,2,0,1,0,0,0,0,0);
    EXI   = pk(0,0,0,0,0,0,2,2,2,1,0,0,0,0,0);
    EXR   = pk(0,0,0,0,0,0,2,0,2,1,0,0,0,0,0);
    WBA   = pk(0,0,0,0,0,0,0,0,0,0,1,0,1,0,0);
    ADR   = pk(0,0,0,0,0,0,2,2,0,1,0,0,0,0,0);
    MRD   = pk(1,0,1,0,0,0,0,0,0,0,0,0,0,0,0);
    WBM   = pk(0,0,0,0,0,0,0,0,0,0,1,1,1,0,0);
    MWR   = pk(1,1,1,0,0,0,0,0,0,0,0,0,0,0,0);
    MWRA  = pk(1,1,1,0,0,0,0,0,0,0,0,0,1,0,0);
    BRT   = pk(0,0,0,0,1,1,2,0,1,0,0,0,1,0,0);
    BRN   = pk(0,0,0,0,0,1,2,0,1,0,0,0,1,0,0);
    WJAL  = pk(0,0,0,0,1,1,0,0,0,0,1,2,1,0,0);
    WJALR = pk(0,0,0,0,1,2,2,2,0,0,1,2,1,0,0);
    WLUI  = pk(0,0,0,0,0,0,0,0,0,0,1,3,1,0,0);
    TR1   = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,1);
    TR2   = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,2);

    rst = 1'b1; instr = '0; mem_if.ack = 1'b0; zero = 1'b0; lt = 1'b0;
    @(posedge clk); #1;
    cyc("reset", 1, ADDI, 0, 0, 0, Z);

    // ADDI, ack on first request; stray ack in DECODE is ignored
    cyc("addi fetch", 0, ADDI, 1, 0, 0, FA);
    cyc("addi decode", 0, ADDI, 1, 0, 0, DEC);
    cyc("addi exec", 0, ADDI, 0, 0, 0, EXI);
    cyc("addi wb", 0, ADDI, 0, 0, 0, WBA);

    // LD: 3 fetch waits, 2 data waits
    for (int i = 0; i < 3; i++) cyc("ld fetch wait", 0, LDI, 0, 0, 0, F);
    cyc("ld fetch ack", 0, LDI, 1, 0, 0, FA);
    cyc("ld decode", 0, LDI, 0, 0, 0, DEC);
    cyc("ld addr", 0, LDI, 0, 0, 0, ADR);
    for (int i = 0; i < 2; i++) cyc("ld mem wait", 0, LDI, 0, 0, 0, MRD);
    cyc("ld mem ack", 0, LDI, 1, 0, 0, MRD);
    cyc("ld wb", 0, LDI, 0, 0, 0, WBM);

    // R-type
    cyc("add fetch", 0, ADDR, 1, 0, 0, FA);
    cyc("add decode", 0, ADDR, 0, 0, 0, DEC);
    cyc("add exec", 0, ADDR, 0, 0, 0, EXR);
    cyc("add wb", 0, ADDR, 0, 0, 0, WBA);

    // Branches: taken/not-taken on zero and lt
    cyc("beq fetch", 0, BEQ, 1, 0, 0, FA);
    cyc("beq decode", 0, BEQ, 0, 0, 0, DEC);
    cyc("beq z=1", 0, BEQ, 0, 1, 0, BRT);
    cyc("beq2 fetch", 0, BEQ, 1, 0, 0, FA);
    cyc("beq2 decode", 0, BEQ, 0, 0, 0, DEC);
    cyc("beq z=0", 0, BEQ, 0, 0, 0, BRN);
    cyc("blt fetch", 0, BLT, 1, 0, 0, FA);
    cyc("blt decode", 0, BLT, 0, 0, 0, DEC);
    cyc("blt lt=1", 0, BLT, 0, 0, 1, BRT);
    cyc("bge fetch", 0, BGE, 1, 0, 0, FA);
    cyc("bge decode", 0, BGE, 0, 0, 0, DEC);
    cyc("bge lt=1", 0, BGE, 0, 0, 1, BRN);

    // Jumps and LUI; LUI fetch acks on the 5th request cycle (limit boundary)
    cyc("jal fetch", 0, JALI, 1, 0, 0, FA);
    cyc("jal decode", 0, JALI, 0, 0, 0, DEC);
    cyc("jal", 0, JALI, 0, 0, 0, WJAL);
    cyc("jalr fetch", 0, JALR, 1, 0, 0, FA);
    cyc("jalr decode", 0, JALR, 0, 0, 0, DEC);
    cyc("jalr", 0, JALR, 0, 0, 0, WJALR);
    for (int i = 0; i < 4; i++) cyc("lui fetch wait", 0, LUI, 0, 0, 0, F);
    cyc("lui fetch ack@limit", 0, LUI, 1, 0, 0, FA);
    cyc("lui decode", 0, LUI, 0, 0, 0, DEC);
    cyc("lui", 0, LUI, 0, 0, 0, WLUI);

    // SD: store acked on the 5th request cycle, timer restarted on MEM_WR entry
    cyc("sd fetch", 0, SD, 1, 0, 0, FA);
    cyc("sd decode", 0, SD, 0, 0, 0, DEC);
    cyc("sd addr", 0, SD, 0, 0, 0, ADR);
    for (int i = 0; i < 4; i++) cyc("sd mem wait", 0, SD, 0, 0, 0, MWR);
    cyc("sd mem ack@limit", 0, SD, 1, 0, 0, MWRA);

    // Reset mid-wait in MEM_WR: no strobes, no retire, back to FETCH
    cyc("sd2 fetch", 0, SD, 1, 0, 0, FA);
    cyc("sd2 decode", 0, SD, 0, 0, 0, DEC);
    cyc("sd2 addr", 0, SD, 0, 0, 0, ADR);
    for (int i = 0; i < 2; i++) cyc("sd2 mem wait", 0, SD, 0, 0, 0, MWR);
    cyc("reset in mem_wr", 1, SD, 1, 0, 0, Z);

    // Timeout in FETCH: 5 request cycles without ack, then trap cause 2
    for (int i = 0; i < 5; i++) cyc("timeout fetch wait", 0, ADDI, 0, 0, 0, F);
    for (int i = 0; i < 3; i++) cyc("timeout trap", 0, ADDI, 1, 0, 0, TR2);
    cyc("reset after timeout", 1, ADDI, 0, 0, 0, Z);

    // Illegal opcode: sticky trap cause 1 for 100 cycles, cleared by reset
    cyc("ill fetch", 0, ILL, 1, 0, 0, FA);
    cyc("ill decode", 0, ILL, 0, 0, 0, DEC);
    for (int i = 0; i < 100; i++) cyc("ill trap", 0, ILL, i[0], 0, 0, TR1);
    cyc("reset after illegal", 1, ILL, 0, 0, 0, Z);
    cyc("fetch after reset", 0, ADDI, 0, 0, 0, F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
